// File: rtl/s_axi.sv
// AXI4 slave backed by a register-array memory.
// Write and read channels are independent FSMs that share only the array.
module s_axi #(
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned MEMSIZE     = 32,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned BUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   xrst,
    input  logic [ID_WIDTH-1:0]    awid,
    input  logic [MEMSIZE-1:0]     awaddr,
    input  logic [7:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DWIDTH-1:0]      wdata,
    input  logic [DWIDTH/8-1:0]    wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [ID_WIDTH-1:0]    bid,
    output logic [1:0]             bresp,
    output logic [BUSER_WIDTH-1:0] buser,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [ID_WIDTH-1:0]    arid,
    input  logic [MEMSIZE-1:0]     araddr,
    input  logic [7:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [ID_WIDTH-1:0]    rid,
    output logic [DWIDTH-1:0]      rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic [RUSER_WIDTH-1:0] ruser,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int unsigned STRB_W   = DWIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned DEPTH    = 1 << MEM_AW;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Unsupported beat size, WRAP/reserved burst, or address beyond the array.
    function automatic logic req_err(input logic [MEMSIZE-1:0] addr,
                                     input logic [2:0]         size,
                                     input logic [1:0]         burst);
        req_err = (size != 3'(ADDR_LSB)) || burst[1]
                  || ((addr >> (MEM_AW + ADDR_LSB)) != '0);
    endfunction

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // ---------------- write channel ----------------
    logic [1:0]          wstate_q, wstate_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic [MEM_AW-1:0]   widx_q, widx_d;
    logic [7:0]          wlen_q, wlen_d;
    logic                wfixed_q, wfixed_d;
    logic                werr_q, werr_d;
    logic [8:0]          wcnt_q, wcnt_d;
    logic [STRB_W-1:0]   mem_we_c;
    logic                wlast_err_c;

    always_comb begin
        wstate_d    = wstate_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wfixed_d    = wfixed_q;
        werr_d      = werr_q;
        wcnt_d      = wcnt_q;
        mem_we_c    = '0;
        wlast_err_c = werr_q || (wcnt_q != {1'b0, wlen_q});

        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = awid;
                    widx_d    = awaddr[MEM_AW+ADDR_LSB-1:ADDR_LSB];
                    wlen_d    = awlen;
                    wfixed_d  = (awburst == 2'b00);
                    werr_d    = req_err(awaddr, awsize, awburst);
                    wcnt_d    = '0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // Beats past the announced length are accepted but dropped.
                    if (!werr_q && (wcnt_q <= {1'b0, wlen_q})) begin
                        mem_we_c = wstrb;
                    end
                    if (!wfixed_q) begin
                        widx_d = widx_q + MEM_AW'(1);
                    end
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                    if (wlast) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        werr_d   = wlast_err_c;
                        bresp_d  = wlast_err_c ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wfixed_q  <= 1'b0;
            werr_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wfixed_q  <= wfixed_d;
            werr_q    <= werr_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Byte-enabled array write; a beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (xrst && mem_we_c[b]) begin
                mem_q[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    logic [0:0]          rstate_q, rstate_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rlast_q, rlast_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [MEM_AW-1:0]   ridx_q, ridx_d;
    logic [7:0]          rlen_q, rlen_d;
    logic                rfixed_q, rfixed_d;
    logic                rerr_q, rerr_d;
    logic [7:0]          rcnt_q, rcnt_d;
    logic [MEM_AW-1:0]   ar_idx_c;
    logic [MEM_AW-1:0]   rnext_idx_c;
    logic                ar_err_c;

    always_comb begin
        rstate_d    = rstate_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        ridx_d      = ridx_q;
        rlen_d      = rlen_q;
        rfixed_d    = rfixed_q;
        rerr_d      = rerr_q;
        rcnt_d      = rcnt_q;
        ar_idx_c    = araddr[MEM_AW+ADDR_LSB-1:ADDR_LSB];
        ar_err_c    = req_err(araddr, arsize, arburst);
        rnext_idx_c = rfixed_q ? ridx_q : ridx_q + MEM_AW'(1);

        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = arid;
                    ridx_d    = ar_idx_c;
                    rlen_d    = arlen;
                    rfixed_d  = (arburst == 2'b00);
                    rerr_d    = ar_err_c;
                    rcnt_d    = '0;
                    rdata_d   = ar_err_c ? '0 : mem_q[ar_idx_c];
                    rlast_d   = (arlen == 8'd0);
                    rresp_d   = ar_err_c ? RESP_SLVERR : RESP_OKAY;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                // Each accepted beat is replaced by the next one on the following cycle.
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        ridx_d  = rnext_idx_c;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = rerr_q ? '0 : mem_q[rnext_idx_c];
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rfixed_q  <= 1'b0;
            rerr_q    <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rfixed_q  <= rfixed_d;
            rerr_q    <= rerr_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign buser   = '0;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign ruser   = '0;

endmodule

// File: tb/tb_s_axi.sv
// Bench for s_axi: randomized bursts checked against an array model of the memory
// whose responses come from the protocol rules (size, burst type, address range, length).
module tb_s_axi;

    logic        clk = 1'b0;
    logic        xrst;
    logic [0:0]  awid, bid, arid, rid, buser, ruser;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model [1024];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    s_axi dut (
        .clk(clk), .xrst(xrst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    // Full write transaction; the model is updated from the protocol rules afterwards.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nbeats, input int bdelay,
                            input logic [0:0] id, input string tag);
        logic       err;
        logic [1:0] exp_resp;
        int         idx, n;
        err = (size != 3'd2) || (burst > 2'd1) || (addr >= 32'h1000);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (awready !== 1'b1) $display("FAIL %s aw_timeout: awready=%b want 1", tag, awready);
        else n_pass++;
        @(posedge clk); #1;
        awvalid = 1'b0;
        n_checks++;
        if (wready !== 1'b1 || awready !== 1'b0)
            $display("FAIL %s w_phase_entry: wready=%b awready=%b want 1/0", tag, wready, awready);
        else n_pass++;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        idx = int'(addr[11:2]);
        if (!err) begin
            for (int i = 0; i < nbeats; i++) begin
                if (i <= int'(len))
                    for (int b = 0; b < 4; b++)
                        if (ws[i][b]) model[idx][b*8 +: 8] = wd[i][b*8 +: 8];
                if (burst == 2'b01) idx = (idx + 1) % 1024;
            end
        end
        if (nbeats != int'(len) + 1) err = 1'b1;
        exp_resp = err ? 2'b10 : 2'b00;
        bready = 1'b0;
        for (int d = 0; d <= bdelay; d++) begin
            if (d == bdelay) bready = 1'b1;
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== exp_resp || bid !== id || wready !== 1'b0)
                $display("FAIL %s b_resp: bvalid=%b bresp=%b bid=%b wready=%b want 1/%b/%b/0",
                         tag, bvalid, bresp, bid, wready, exp_resp, id);
            else n_pass++;
            @(posedge clk); #1;
        end
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1)
            $display("FAIL %s b_done: bvalid=%b awready=%b want 0/1", tag, bvalid, awready);
        else n_pass++;
    endtask

    // Full read transaction; mode 0 = rready high, 1 = toggle, 2 = random.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [0:0] id, input int mode,
                           input string tag);
        logic        err, rr;
        logic [1:0]  exp_resp;
        logic [31:0] exp_q [$];
        int          idx, beat, cyc, n;
        err = (size != 3'd2) || (burst > 2'd1) || (addr >= 32'h1000);
        exp_resp = err ? 2'b10 : 2'b00;
        idx = int'(addr[11:2]);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(err ? 32'h0 : model[idx]);
            if (burst == 2'b01) idx = (idx + 1) % 1024;
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (arready !== 1'b1) $display("FAIL %s ar_timeout: arready=%b want 1", tag, arready);
        else n_pass++;
        @(posedge clk); #1;
        arvalid = 1'b0;
        beat = 0; cyc = 0;
        while (beat <= int'(len)) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 2 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp_q[beat] || rlast !== (beat == int'(len))
                || rresp !== exp_resp || rid !== id || arready !== 1'b0)
                $display("FAIL %s r_beat%0d: rvalid=%b rdata=%h rlast=%b rresp=%b rid=%b want 1/%h/%b/%b/%b",
                         tag, beat, rvalid, rdata, rlast, rresp, rid,
                         exp_q[beat], (beat == int'(len)), exp_resp, id);
            else n_pass++;
            @(posedge clk); #1;
            if (rr) beat++;
            cyc++;
        end
        rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1)
            $display("FAIL %s r_done: rvalid=%b arready=%b want 0/1", tag, rvalid, arready);
        else n_pass++;
    endtask

    task automatic test_reset();
        xrst = 1'b0;
        awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid} !== '0)
            $display("FAIL reset_outputs: awready=%b arready=%b bvalid=%b rvalid=%b rdata=%h want all 0",
                     awready, arready, bvalid, rvalid, rdata);
        else n_pass++;
        xrst = 1'b1;
        n_checks++;
        if (awready !== 1'b0 || arready !== 1'b0)
            $display("FAIL reset_release_same_cycle: awready=%b arready=%b want 0/0", awready, arready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (awready !== 1'b1 || arready !== 1'b1)
            $display("FAIL reset_ready_up: awready=%b arready=%b want 1/1", awready, arready);
        else n_pass++;
    endtask

    task automatic test_incr16();
        for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
        do_write(32'h0, 8'd15, 3'd2, 2'b01, 16, 1, 1'b0, "incr16_wr");
        do_read(32'h0, 8'd15, 3'd2, 2'b01, 1'b0, 0, "incr16_rd");
    endtask

    task automatic test_strobe();
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(32'hC, 8'd0, 3'd2, 2'b01, 1, 0, 1'b1, "strb_full");
        wd[0] = 32'h0000_1234; ws[0] = 4'b0011;
        do_write(32'hC, 8'd0, 3'd2, 2'b01, 1, 0, 1'b1, "strb_part");
        do_read(32'hC, 8'd0, 3'd2, 2'b01, 1'b1, 0, "strb_rd");
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hDEAD_0000 + i; ws[i] = 4'hF; end
        do_write(32'h1000, 8'd3, 3'd2, 2'b01, 4, 0, 1'b0, "oor_wr");
        do_read(32'h1000, 8'd3, 3'd2, 2'b01, 1'b0, 0, "oor_rd");
        do_read(32'h8000_0004, 8'd1, 3'd2, 2'b00, 1'b1, 0, "oor_hi_rd");
        do_read(32'h0, 8'd3, 3'd2, 2'b01, 1'b0, 0, "oor_unchanged");
    endtask

    task automatic test_protocol_errors();
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h100, 8'd3, 3'd1, 2'b01, 4, 0, 1'b0, "bad_size");
        do_write(32'h100, 8'd3, 3'd2, 2'b10, 4, 0, 1'b1, "bad_burst");
        do_write(32'h100, 8'd3, 3'd2, 2'b01, 2, 0, 1'b0, "early_wlast");
        do_write(32'h140, 8'd1, 3'd2, 2'b01, 4, 2, 1'b1, "extra_beats");
        do_read(32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 0, "err_region_rd");
        do_read(32'h140, 8'd3, 3'd2, 2'b01, 1'b1, 0, "extra_region_rd");
        do_read(32'h100, 8'd1, 3'd0, 2'b01, 1'b0, 0, "rd_bad_size");
        do_read(32'h100, 8'd1, 3'd2, 2'b11, 1'b1, 0, "rd_bad_burst");
    endtask

    task automatic test_rready_toggle();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA5A5_0000 | (i << 8) | i; ws[i] = 4'hF; end
        do_write(32'h200, 8'd3, 3'd2, 2'b01, 4, 0, 1'b0, "tog_wr");
        do_read(32'h200, 8'd3, 3'd2, 2'b01, 1'b0, 1, "tog_rd");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [0:0]  id;
        for (int t = 0; t < 8; t++) begin
            addr  = 32'($urandom_range(64, 900)) << 2;
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 1));
            id    = 1'($urandom_range(0, 1));
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(addr, len, 3'd2, burst, int'(len) + 1, $urandom_range(0, 2), id, "rnd_full");
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(addr, len, 3'd2, burst, int'(len) + 1, $urandom_range(0, 2), ~id, "rnd_strb");
            do_read(addr, len, 3'd2, burst, id, 2, "rnd_rd");
        end
    endtask

    // AW and AR presented in the same cycle on disjoint regions.
    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin wd[i] = 32'h5000_0000 + i; ws[i] = 4'hF; end
        fork
            do_write(32'h300, 8'd5, 3'd2, 2'b01, 6, 0, 1'b1, "par_wr");
            do_read(32'h0, 8'd15, 3'd2, 2'b01, 1'b0, 2, "par_rd");
        join
        do_read(32'h300, 8'd5, 3'd2, 2'b01, 1'b1, 0, "par_check");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h1111_0000 + i; ws[i] = 4'hF; end
        do_write(32'h400, 8'd7, 3'd2, 2'b01, 8, 0, 1'b0, "mid_pre");
        awid = 1'b1; awaddr = 32'h400; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata = 32'h2222_0000 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            n_checks++;
            if (wready !== 1'b1) $display("FAIL mid_wready_beat%0d: wready=%b want 1", i, wready);
            else n_pass++;
            @(posedge clk); #1;
            model[256 + i] = 32'h2222_0000 + i;
        end
        wdata = 32'h2222_0004; xrst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid} !== '0)
            $display("FAIL mid_reset_outputs: awready=%b wready=%b bvalid=%b arready=%b want all 0",
                     awready, wready, bvalid, arready);
        else n_pass++;
        xrst = 1'b1; wvalid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b0)
            $display("FAIL mid_recover: awready=%b wready=%b want 1/0", awready, wready);
        else n_pass++;
        do_read(32'h400, 8'd7, 3'd2, 2'b01, 1'b0, 0, "mid_partial");
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h3333_0000 + i; ws[i] = 4'hF; end
        do_write(32'h400, 8'd7, 3'd2, 2'b01, 8, 1, 1'b1, "mid_new_wr");
        do_read(32'h400, 8'd7, 3'd2, 2'b01, 1'b1, 2, "mid_new_rd");
    endtask

    initial begin
        test_reset();
        test_incr16();
        test_strobe();
        test_out_of_range();
        test_protocol_errors();
        test_rready_toggle();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/s_axi.md
Name: s_axi

Overview:
AXI4 full slave (responder) backed by an internal register-array memory. It is the counterpart of the existing AXI4 master traffic generator: it accepts its INCR write bursts, stores the data, and returns the data on read bursts. It is used as the loopback target in block and system benches, and as a small scratch memory behind an interconnect. The write and read channels are independent state machines that share only the memory array.

Parameters:
ID_WIDTH, 1, width of awid/bid/arid/rid
DWIDTH, 32, data width in bits; must be a power of 2 and at least 8
MEMSIZE, 32, address width in bits
MEM_AW, 10, log2 of the memory depth in DWIDTH-bit words
BUSER_WIDTH, 1, width of buser
RUSER_WIDTH, 1, width of ruser

Ports:
clk  in  1  clock
xrst  in  1  reset; synchronous, active-low
awid  in  ID_WIDTH  write ID
awaddr  in  MEMSIZE  write byte address
awlen  in  8  beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  burst type
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DWIDTH  write data
wstrb  in  DWIDTH/8  byte strobes
wlast  in  1  last write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  ID_WIDTH  echoes awid
bresp  out  2  write response
buser  out  BUSER_WIDTH  tied 0
bvalid  out  1  write response valid
bready  in  1  write response ready
arid  in  ID_WIDTH  read ID
araddr  in  MEMSIZE  read byte address
arlen  in  8  beats minus 1
arsize  in  3  log2 bytes per beat
arburst  in  2  burst type
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  ID_WIDTH  echoes arid
rdata  out  DWIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat
ruser  out  RUSER_WIDTH  tied 0
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset (xrst=0 at a clk edge): both FSMs go to IDLE. All outputs are 0, including awready and arready. The memory array is not cleared.
- Memory word index = addr[MEM_AW+ADDR_LSB-1:ADDR_LSB], where ADDR_LSB = clog2(DWIDTH/8). Any nonzero address bit at or above MEM_AW+ADDR_LSB marks the address out of range.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1, registered, so it is first seen the cycle after reset deasserts.
  - AW handshake: latch id, word index, len and burst type. Set an error flag if awsize != ADDR_LSB, the burst type is not FIXED (00) or INCR (01), or the address is out of range. Next cycle: awready=0, wready=1, state W_DATA.
  - W_DATA: each wvalid&&wready beat writes the bytes selected by wstrb, but only when the error flag is clear and the beat count is within awlen+1. Beats beyond awlen+1 are discarded.
  - Address step: INCR adds 1 word per beat and wraps modulo the memory depth. FIXED does not advance.
  - The wlast beat ends the phase. If wlast does not coincide with beat awlen+1, set the error flag. Next cycle: wready=0, bvalid=1, bresp=10 (SLVERR) if the error flag is set, else 00. The state becomes W_RESP.
  - W_RESP: bid, bresp and bvalid are held stable until bready. On the bvalid&&bready cycle the FSM returns to W_IDLE, and awready=1 the next cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1, registered.
  - AR handshake: latch the request and set the error flag under the same rules as the write side. Next cycle: arready=0, rvalid=1, rdata=mem[index] (0 if error), rlast=(arlen==0), rresp=10 if error, else 00.
  - R_DATA: rdata, rresp, rlast and rid are held stable while rvalid && !rready. Each handshake presents the next beat on the following cycle, so there are no bubbles while rready stays high.
  - The rlast handshake clears rvalid and returns to R_IDLE, with arready=1 the next cycle.
- Read data is registered from the memory. A read and a write to the same word in the same cycle returns the old data.
- Channels are fully independent; simultaneous AW and AR handshakes are both accepted.
- Reset mid-burst aborts both FSMs immediately. The partially written memory contents remain.

Test Plan:
- Write 16-beat INCR burst at awaddr 0 with data 0..15 and wstrb all ones, bready delayed 1 cycle -> bresp=00. Then read 16 beats at 0 -> rdata 0..15, rlast only on beat 16.
- Loopback with the existing master (BURST_LEN 16, DWIDTH 32) after req pulse -> master ack=1, err=0.
- Write 0xFFFFFFFF to word 3, then a single beat to word 3 with wstrb=0011 and data 0x00001234 -> read returns 0xFFFF1234.
- awaddr = 1<<(MEM_AW+2) -> bresp=10 and memory unchanged. Read of the same address -> rdata=0, rresp=10 on every beat.
- Read with rready toggling 1/0 every cycle -> rdata/rlast held while stalled; 4-beat burst completes with no data lost or repeated.
- xrst low during W_DATA beat 5 of 8 -> next cycle all outputs 0; awready=1 one cycle after xrst returns high; a new burst completes normally.
